// File: rtl/core_run_sequencer.sv
// core_run_sequencer
//   Host-side initiator for a processor start/done handshake. A run request
//   holds the core in reset, pulses start, then counts RUN cycles until a
//   debounced done or a watchdog timeout, and returns a cycle-count/status
//   response.
//
// Ports:
//   clk          system clock, rising edge
//   reset        synchronous active-low reset (0 = reset)
//   req_valid    host requests a run
//   req_ready    request can be accepted (IDLE only, combinational)
//   core_reset   active-high reset to the processor
//   core_start   start strobe to the processor
//   core_done    processor done/halt indication
//   rsp_valid    run result available
//   rsp_ready    host accepts result
//   rsp_cycles   RUN cycles counted, including the qualifying cycle
//   rsp_timeout  run ended by watchdog
//
// Optional feature (macro RUN_SEQ_ABORT_EN):
//   abort        forces the current run to REPORT (RUN state only)
//   rsp_aborted  run ended by abort
module core_run_sequencer #(
    parameter int RST_CYCLES   = 2,
    parameter int START_CYCLES = 1,
    parameter int DONE_STABLE  = 2,
    parameter int CNT_W        = 16,
    parameter int TIMEOUT      = 4095
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    output logic             core_reset,
    output logic             core_start,
    input  logic             core_done,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [CNT_W-1:0] rsp_cycles,
    output logic             rsp_timeout
`ifdef RUN_SEQ_ABORT_EN
    ,
    input  logic             abort,
    output logic             rsp_aborted
`endif
);

    localparam int PH_MAX = (RST_CYCLES > START_CYCLES) ? RST_CYCLES : START_CYCLES;
    localparam int PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam int ST_W   = $clog2(DONE_STABLE + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_START,
        S_RUN,
        S_REPORT
    } state_t;

    state_t           state;
    logic [PH_W-1:0]  phase;
    logic [CNT_W-1:0] cnt;
    logic [ST_W-1:0]  stable;

    logic [CNT_W-1:0] cnt_next;
    logic [ST_W-1:0]  stable_next;
    logic             qualify;
    logic             hit_timeout;

    assign req_ready = (state == S_IDLE);

    // cnt holds the number of completed RUN cycles, so cnt_next is the
    // index k of the cycle currently being evaluated (first RUN cycle is 1).
    // The stable counter never exceeds DONE_STABLE because reaching it
    // leaves RUN.
    always_comb begin
        cnt_next    = cnt + CNT_W'(1);
        stable_next = core_done ? (stable + ST_W'(1)) : '0;
        qualify     = (stable_next == ST_W'(DONE_STABLE));
        hit_timeout = (cnt_next == CNT_W'(TIMEOUT));
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_IDLE;
            phase       <= '0;
            cnt         <= '0;
            stable      <= '0;
            core_reset  <= 1'b1;
            core_start  <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_cycles  <= '0;
            rsp_timeout <= 1'b0;
`ifdef RUN_SEQ_ABORT_EN
            rsp_aborted <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        state      <= S_RST;
                        phase      <= '0;
                        core_reset <= 1'b1;
                        core_start <= 1'b0;
                    end
                end
                S_RST: begin
                    if (phase == PH_W'(RST_CYCLES - 1)) begin
                        state      <= S_START;
                        phase      <= '0;
                        core_reset <= 1'b0;
                        core_start <= 1'b1;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_START: begin
                    if (phase == PH_W'(START_CYCLES - 1)) begin
                        state      <= S_RUN;
                        phase      <= '0;
                        core_start <= 1'b0;
                        cnt        <= '0;
                        stable     <= '0;
                    end else begin
                        phase <= phase + PH_W'(1);
                    end
                end
                S_RUN: begin
                    cnt    <= cnt_next;
                    stable <= stable_next;
                    // Priority: qualify > abort > timeout.
                    if (qualify) begin
                        state       <= S_REPORT;
                        rsp_valid   <= 1'b1;
                        rsp_cycles  <= cnt_next;
                        rsp_timeout <= 1'b0;
`ifdef RUN_SEQ_ABORT_EN
                        rsp_aborted <= 1'b0;
                    end else if (abort) begin
                        state       <= S_REPORT;
                        rsp_valid   <= 1'b1;
                        rsp_cycles  <= cnt_next;
                        rsp_timeout <= 1'b0;
                        rsp_aborted <= 1'b1;
`endif
                    end else if (hit_timeout) begin
                        state       <= S_REPORT;
                        rsp_valid   <= 1'b1;
                        rsp_cycles  <= CNT_W'(TIMEOUT);
                        rsp_timeout <= 1'b1;
`ifdef RUN_SEQ_ABORT_EN
                        rsp_aborted <= 1'b0;
`endif
                    end
                end
                S_REPORT: begin
                    if (rsp_ready) begin
                        state     <= S_IDLE;
                        rsp_valid <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_sequencer.sv
// tb_core_run_sequencer
//   Directed bench for core_run_sequencer (TIMEOUT overridden to 20, other
//   parameters default). Inputs are driven and outputs sampled 1 time unit
//   after each rising edge. Build with RUN_SEQ_ABORT_EN to cover abort.
module tb_core_run_sequencer;

    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic             req_valid;
    logic             req_ready;
    logic             core_reset;
    logic             core_start;
    logic             core_done;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [CNT_W-1:0] rsp_cycles;
    logic             rsp_timeout;
`ifdef RUN_SEQ_ABORT_EN
    logic             abort;
    logic             rsp_aborted;
`endif

    int compared   = 0;
    int mismatched = 0;
    int abort_at   = 0;

    always #5 clk = ~clk;

    core_run_sequencer #(
        .RST_CYCLES  (2),
        .START_CYCLES(1),
        .DONE_STABLE (2),
        .CNT_W       (CNT_W),
        .TIMEOUT     (20)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .core_reset (core_reset),
        .core_start (core_start),
        .core_done  (core_done),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_cycles (rsp_cycles),
        .rsp_timeout(rsp_timeout)
`ifdef RUN_SEQ_ABORT_EN
        ,
        .abort      (abort),
        .rsp_aborted(rsp_aborted)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // From an IDLE window: issue a request and walk RST/START, ending in the
    // window of RUN cycle 1.
    task automatic do_request;
        req_valid = 1'b1;
        chk("idle_req_ready", req_ready, 1);
        tick;
        req_valid = 1'b0;
        chk("rst1_core_reset", core_reset, 1);
        chk("rst1_core_start", core_start, 0);
        chk("rst1_req_ready", req_ready, 0);
        tick;
        chk("rst2_core_reset", core_reset, 1);
        chk("rst2_core_start", core_start, 0);
        tick;
        chk("start_core_reset", core_reset, 0);
        chk("start_core_start", core_start, 1);
        tick;
        chk("run1_core_start", core_start, 0);
        chk("run1_core_reset", core_reset, 0);
    endtask

    // Drive n RUN cycles; core_done is high from cycle done_from onward and
    // also in cycle glitch. No response may appear before the n-th edge.
    task automatic run_cycles(input int n, input int done_from, input int glitch);
        for (int k = 1; k <= n; k++) begin
            core_done = (k >= done_from) || (k == glitch);
`ifdef RUN_SEQ_ABORT_EN
            abort = (k == abort_at);
`endif
            chk("run_no_rsp", rsp_valid, 0);
            chk("run_req_ready", req_ready, 0);
            tick;
        end
        core_done = 1'b0;
`ifdef RUN_SEQ_ABORT_EN
        abort = 1'b0;
`endif
    endtask

    task automatic ack;
        rsp_ready = 1'b1;
        tick;
        rsp_ready = 1'b0;
        chk("ack_rsp_valid", rsp_valid, 0);
        chk("ack_req_ready", req_ready, 1);
        chk("ack_core_reset", core_reset, 0);
    endtask

    initial begin
        reset     = 1'b0;
        req_valid = 1'b0;
        core_done = 1'b0;
        rsp_ready = 1'b0;
`ifdef RUN_SEQ_ABORT_EN
        abort     = 1'b0;
`endif
        tick;
        tick;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_core_start", core_start, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_cycles", rsp_cycles, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_req_ready", req_ready, 1);
        reset = 1'b1;
        tick;
        chk("idle_core_reset_held", core_reset, 1);
        rsp_ready = 1'b1;  // ignored outside REPORT
        tick;
        rsp_ready = 1'b0;
        chk("idle_rsp_ready_ignored", req_ready, 1);

        // Done rises in cycle 5 and stays: qualifies in cycle 6.
        do_request;
        run_cycles(6, 5, 0);
        chk("t2_rsp_valid", rsp_valid, 1);
        chk("t2_rsp_cycles", rsp_cycles, 6);
        chk("t2_rsp_timeout", rsp_timeout, 0);
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("t2_hold_valid", rsp_valid, 1);
            chk("t2_hold_cycles", rsp_cycles, 6);
            chk("t2_hold_timeout", rsp_timeout, 0);
            chk("t2_hold_core_reset", core_reset, 0);
        end
        ack;

        // Back-to-back: single-cycle glitch at 3 ignored, done from 10.
        do_request;
        run_cycles(11, 10, 3);
        chk("t3_rsp_valid", rsp_valid, 1);
        chk("t3_rsp_cycles", rsp_cycles, 11);
        chk("t3_rsp_timeout", rsp_timeout, 0);
        ack;

        // Watchdog: done never rises.
        do_request;
        run_cycles(20, 1000, 0);
        chk("t4_rsp_valid", rsp_valid, 1);
        chk("t4_rsp_cycles", rsp_cycles, 20);
        chk("t4_rsp_timeout", rsp_timeout, 1);
        ack;
        chk("t4_idle_core_reset", core_reset, 0);

        // Next request re-asserts core_reset; req_valid in RUN is ignored;
        // reset during RUN cycle 7 abandons the run.
        do_request;
        req_valid = 1'b1;
        run_cycles(6, 1000, 0);
        req_valid = 1'b0;
        reset = 1'b0;
        tick;
        reset = 1'b1;
        chk("t5_req_ready", req_ready, 1);
        chk("t5_core_reset", core_reset, 1);
        chk("t5_core_start", core_start, 0);
        chk("t5_rsp_valid", rsp_valid, 0);
        chk("t5_rsp_cycles", rsp_cycles, 0);
        for (int i = 0; i < 25; i++) begin
            tick;
            chk("t5_no_rsp", rsp_valid, 0);
            chk("t5_idle", req_ready, 1);
        end

`ifdef RUN_SEQ_ABORT_EN
        abort = 1'b1;  // ignored in IDLE
        tick;
        abort = 1'b0;
        chk("t6_idle_abort_ignored", req_ready, 1);
        abort_at = 4;
        do_request;
        run_cycles(4, 1000, 0);
        chk("t6_rsp_valid", rsp_valid, 1);
        chk("t6_rsp_cycles", rsp_cycles, 4);
        chk("t6_rsp_aborted", rsp_aborted, 1);
        chk("t6_rsp_timeout", rsp_timeout, 0);
        ack;
        abort_at = 6;
        do_request;
        run_cycles(6, 5, 0);
        chk("t6q_rsp_valid", rsp_valid, 1);
        chk("t6q_rsp_cycles", rsp_cycles, 6);
        chk("t6q_rsp_aborted", rsp_aborted, 0);
        ack;
        abort_at = 0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/core_run_sequencer.md
Name: core_run_sequencer

Overview:
- Host-side initiator for the processor's start/done handshake.
- Accepts a run request, then holds the core in reset, pulses start, and counts cycles until a qualified done or a watchdog timeout.
- Returns a cycle-count/status response.
- Sits between the testbench/host harness and the processor top level, one instance per core.

Parameters:
RST_CYCLES, 2, cycles core_reset held high per run (>=1)
START_CYCLES, 1, cycles core_start held high after core reset (>=1)
DONE_STABLE, 2, consecutive high core_done samples required to qualify completion (>=1)
CNT_W, 16, width of cycle counter and rsp_cycles
TIMEOUT, 4095, RUN-cycle limit before abort (1 .. 2^CNT_W-1)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-low reset (0 = reset)
req_valid  input  1  host requests a run
req_ready  output  1  sequencer can accept a request (IDLE only)
core_reset  output  1  active-high reset to processor
core_start  output  1  start strobe to processor
core_done  input  1  processor done/halt indication
rsp_valid  output  1  run result available
rsp_ready  input  1  host accepts result
rsp_cycles  output  CNT_W  RUN cycles counted, including the qualifying cycle
rsp_timeout  output  1  run ended by watchdog

Behaviour:
- Reset (reset=0 at a clock edge):
  - State goes to IDLE.
  - core_reset=1, core_start=0.
  - rsp_valid=0, rsp_cycles=0, rsp_timeout=0.
  - Cycle and stable counters clear.
  - Reset mid-run abandons the run; no response is issued.
- All outputs are registered except req_ready, which is (state==IDLE).
- States: IDLE -> RST -> START -> RUN -> REPORT -> IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready at edge T, go to RST at T+1.
  - core_reset keeps its prior value: 1 after sequencer reset, 0 after a completed run.
- RST:
  - core_reset=1, core_start=0 for exactly RST_CYCLES cycles, then START.
- START:
  - core_reset=0, core_start=1 for exactly START_CYCLES cycles, then RUN.
  - core_done is ignored in RST and START.
- RUN:
  - core_start=0.
  - Cycle counter is 0 on entry and increments every RUN cycle; its value in cycle k is k.
  - Stable counter increments while core_done=1 and clears to 0 when core_done=0.
  - Qualify when the stable counter reaches DONE_STABLE. Load rsp_cycles=k and rsp_timeout=0, go to REPORT.
  - Timeout when k==TIMEOUT without qualify. Load rsp_cycles=TIMEOUT and rsp_timeout=1, go to REPORT.
  - Qualify and timeout in the same cycle: qualify wins (rsp_timeout=0).
  - The counter never exceeds TIMEOUT; no wrap.
- REPORT:
  - rsp_valid=1.
  - rsp_cycles and rsp_timeout are held stable until rsp_ready=1 at an edge; then rsp_valid=0 and go to IDLE.
  - core_reset stays 0 so core state remains inspectable.
  - The core stays halted at the done PC on success; on timeout it is left running, then reset by the next RST.
- req_valid outside IDLE is ignored (req_ready=0); no queueing.
- rsp_ready outside REPORT is ignored.
- A back-to-back request may be accepted in the cycle after the REPORT handshake.
- DONE_STABLE filters transient done from combinational PC compare; a done pulse shorter than DONE_STABLE never qualifies.

Optional Feature:
- Macro: RUN_SEQ_ABORT_EN.
- When defined:
  - Adds input abort (1 bit) and output rsp_aborted (1 bit, reset 0).
  - abort=1 in RUN forces REPORT next cycle with rsp_aborted=1, rsp_timeout=0, rsp_cycles=current k.
  - abort in other states is ignored.
  - Priority in RUN: qualify > abort > timeout.
- When undefined: no such ports exist, and behaviour is exactly as above.

Test Plan:
1. Reset with defaults -> core_reset=1, rsp_valid=0, req_ready=1. Request at T -> core_reset=1 at T+1..T+2, core_start=1 at T+3, RUN starts T+4.
2. core_done rises in RUN cycle 5 and stays high (DONE_STABLE=2) -> rsp_valid=1, rsp_cycles=6, rsp_timeout=0. Hold rsp_ready=0 for 3 cycles -> outputs unchanged; then rsp_ready=1 -> IDLE.
3. core_done glitches high for 1 cycle in RUN cycle 3, then rises for good in cycle 10 -> rsp_cycles=11.
4. TIMEOUT=20, core_done never rises -> rsp_timeout=1, rsp_cycles=20. Next request re-asserts core_reset for 2 cycles.
5. reset=0 asserted during RUN cycle 7 -> next cycle IDLE, core_reset=1, no rsp_valid. req_valid during RUN -> req_ready=0, ignored.
6. With RUN_SEQ_ABORT_EN: abort in RUN cycle 4 -> rsp_aborted=1, rsp_cycles=4. Abort in the same cycle as qualify -> rsp_aborted=0.
